// File: rtl/alu_sequencer.sv
// Command sequencer for the ALU_unit datapath. It owns the operand register file,
// issues registered operands to the ALU and writes the result back after ALU_LATENCY.
module alu_sequencer #(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 4,
  parameter int REG_AW      = 3,
  parameter int ALU_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [REG_AW-1:0] cmd_ra,
  input  logic [REG_AW-1:0] cmd_rb,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic              cmd_use_carry,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] alu_opA,
  output logic [DATA_W-1:0] alu_opB,
  output logic [OP_W-1:0]   alu_opcode,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  output logic [DATA_W-1:0] data_out,
  output logic              carry_flag,
  output logic              done,
  output logic              busy
);

  localparam int NREG  = 1 << REG_AW;
  localparam int CNT_W = $clog2(ALU_LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   rf_q [NREG];
  logic [DATA_W-1:0]   rf_d [NREG];
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   load_val_q, load_val_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_opa_q, alu_opa_d;
  logic [DATA_W-1:0]   alu_opb_q, alu_opb_d;
  logic [OP_W-1:0]     alu_opcode_q, alu_opcode_d;
  logic                alu_cin_q, alu_cin_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                carry_flag_q, carry_flag_d;
  logic                done_q, done_d;

  always_comb begin
    state_d      = state_q;
    rf_d         = rf_q;
    rd_d         = rd_q;
    load_val_d   = load_val_q;
    cnt_d        = cnt_q;
    alu_opa_d    = alu_opa_q;
    alu_opb_d    = alu_opb_q;
    alu_opcode_d = alu_opcode_q;
    alu_cin_d    = alu_cin_q;
    data_out_d   = data_out_q;
    carry_flag_d = carry_flag_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rd_d = cmd_rd;
          if (cmd_load) begin
            load_val_d = data_in;
            state_d    = LOAD;
          end else begin
            alu_opa_d    = rf_q[cmd_ra];
            alu_opb_d    = rf_q[cmd_rb];
            alu_opcode_d = cmd_op;
            alu_cin_d    = cmd_use_carry & carry_flag_q;
            cnt_d        = '0;
            state_d      = WAIT;
          end
        end
      end
      LOAD: begin
        rf_d[rd_q] = load_val_q;
        data_out_d = load_val_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      WAIT: begin
        // cnt reaches ALU_LATENCY on the edge where alu_result is valid
        if (cnt_q == CNT_W'(ALU_LATENCY)) begin
          rf_d[rd_q]   = alu_result;
          data_out_d   = alu_result;
          carry_flag_d = alu_cout;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      rd_q         <= '0;
      load_val_q   <= '0;
      cnt_q        <= '0;
      alu_opa_q    <= '0;
      alu_opb_q    <= '0;
      alu_opcode_q <= '0;
      alu_cin_q    <= 1'b0;
      data_out_q   <= '0;
      carry_flag_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_q         <= rf_d;
      rd_q         <= rd_d;
      load_val_q   <= load_val_d;
      cnt_q        <= cnt_d;
      alu_opa_q    <= alu_opa_d;
      alu_opb_q    <= alu_opb_d;
      alu_opcode_q <= alu_opcode_d;
      alu_cin_q    <= alu_cin_d;
      data_out_q   <= data_out_d;
      carry_flag_q <= carry_flag_d;
      done_q       <= done_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign alu_opA    = alu_opa_q;
  assign alu_opB    = alu_opb_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_cin    = alu_cin_q;
  assign data_out   = data_out_q;
  assign carry_flag = carry_flag_q;
  assign done       = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: one-cycle behavioural ALU, transaction-level reference
// model compared on every falling edge, plus directed literal expectations.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_load = 1'b0, cmd_use_carry = 1'b0;
  logic [3:0] cmd_op = 4'h0;
  logic [2:0] cmd_ra = 3'd0, cmd_rb = 3'd0, cmd_rd = 3'd0;
  logic [7:0] data_in = 8'h00, alu_opA, alu_opB, alu_result, data_out;
  logic [3:0] alu_opcode;
  logic       alu_cin, alu_cout, carry_flag, done, busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(8), .OP_W(4), .REG_AW(3), .ALU_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_rd(cmd_rd), .cmd_use_carry(cmd_use_carry), .data_in(data_in),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout), .data_out(data_out),
    .carry_flag(carry_flag), .done(done), .busy(busy)
  );

  // Behavioural ALU: one register stage; op 0 = ADD with carry-in, op 1 = SUB with borrow out
  always @(posedge clk) begin
    if (rst) begin
      alu_result <= 8'h00;
      alu_cout   <= 1'b0;
    end else begin
      case (alu_opcode)
        4'h0:    {alu_cout, alu_result} <= {1'b0, alu_opA} + {1'b0, alu_opB} + {8'h00, alu_cin};
        4'h1:    {alu_cout, alu_result} <= {1'b0, alu_opA} - {1'b0, alu_opB};
        default: {alu_cout, alu_result} <= 9'h000;
      endcase
    end
  end

  // Reference model, transaction level: remaining-cycles counter per command
  int m_rf [8];
  int m_rem = 0, m_rd = 0, m_val = 0, m_cout = 0;
  int m_opa = 0, m_opb = 0, m_op = 0, m_cin = 0, m_dout = 0, m_carry = 0, m_done = 0;

  always @(posedge clk) begin
    int ready0;
    int sum;
    ready0 = (m_rem == 0);
    if (rst) begin
      foreach (m_rf[i]) m_rf[i] = 0;
      m_rem = 0; m_opa = 0; m_opb = 0; m_op = 0; m_cin = 0;
      m_dout = 0; m_carry = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_rf[m_rd] = m_val;
          m_dout     = m_val;
          if (m_cout >= 0) m_carry = m_cout;
          m_done     = 1;
        end
      end
      if (ready0 && cmd_valid) begin
        m_rd = int'(cmd_rd);
        if (cmd_load) begin
          m_val  = int'(data_in);
          m_cout = -1;
          m_rem  = 1;
        end else begin
          m_opa = m_rf[cmd_ra];
          m_opb = m_rf[cmd_rb];
          m_op  = int'(cmd_op);
          m_cin = (cmd_use_carry && m_carry == 1) ? 1 : 0;
          if (m_op == 0) begin
            sum    = m_opa + m_opb + m_cin;
            m_val  = sum % 256;
            m_cout = (sum > 255) ? 1 : 0;
          end else if (m_op == 1) begin
            m_val  = (m_opa - m_opb + 256) % 256;
            m_cout = (m_opa < m_opb) ? 1 : 0;
          end else begin
            m_val  = 0;
            m_cout = 0;
          end
          m_rem = 2;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle compare against the reference model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", int'(cmd_ready), (m_rem == 0) ? 1 : 0);
      chk("busy", int'(busy), (m_rem != 0) ? 1 : 0);
      chk("done", int'(done), m_done);
      chk("data_out", int'(data_out), m_dout);
      chk("carry_flag", int'(carry_flag), m_carry);
      chk("alu_opA", int'(alu_opA), m_opa);
      chk("alu_opB", int'(alu_opB), m_opb);
      chk("alu_opcode", int'(alu_opcode), m_op);
      chk("alu_cin", int'(alu_cin), m_cin);
    end
  end

  task automatic send(input bit ld, input logic [3:0] op, input logic [2:0] ra,
                      input logic [2:0] rb, input logic [2:0] rd, input bit uc,
                      input logic [7:0] din);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_ra = ra; cmd_rb = rb;
    cmd_rd = rd; cmd_use_carry = uc; data_in = din;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    // 1. reset for two cycles
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_alu_opA", int'(alu_opA), 0);

    // 2. single load
    send(1'b1, 4'h0, 3'd0, 3'd0, 3'd2, 1'b0, 8'h3C);
    wait_done();
    chk("load_r2", int'(data_out), 8'h3C);

    // 3. loads then ADD r3 = r0 + r1
    send(1'b1, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 8'hF0);
    wait_done();
    send(1'b1, 4'h0, 3'd0, 3'd0, 3'd1, 1'b0, 8'h20);
    wait_done();
    send(1'b0, 4'h0, 3'd0, 3'd1, 3'd3, 1'b0, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("add_opA", int'(alu_opA), 8'hF0);
    chk("add_opB", int'(alu_opB), 8'h20);
    wait_done();
    chk("add_result", int'(data_out), 8'h10);
    chk("add_carry", int'(carry_flag), 1);

    // 4. carry-in on and off
    send(1'b0, 4'h0, 3'd1, 3'd1, 3'd4, 1'b1, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cin_on", int'(alu_cin), 1);
    wait_done();
    chk("add_cin_result", int'(data_out), 8'h41);
    chk("add_cin_carry", int'(carry_flag), 0);
    send(1'b0, 4'h0, 3'd1, 3'd1, 3'd4, 1'b0, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cin_off", int'(alu_cin), 0);
    wait_done();
    chk("add_nocin_result", int'(data_out), 8'h40);

    // SUB r5 = r1 - r0 borrows
    send(1'b0, 4'h1, 3'd1, 3'd0, 3'd5, 1'b0, 8'h00);
    wait_done();
    chk("sub_result", int'(data_out), 8'h30);
    chk("sub_borrow", int'(carry_flag), 1);

    // 5. back-to-back: r6 = r1 + r1, then r7 = r6 + r0 using the fresh r6
    send(1'b0, 4'h0, 3'd1, 3'd1, 3'd6, 1'b0, 8'h00);
    send(1'b0, 4'h0, 3'd6, 3'd0, 3'd7, 1'b0, 8'h00);
    wait_done();
    chk("b2b_result", int'(data_out), 8'h30);
    chk("b2b_carry", int'(carry_flag), 1);

    // 6. reset during WAIT discards the command
    send(1'b0, 4'h0, 3'd0, 3'd0, 3'd3, 1'b0, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_done", int'(done), 0);
    chk("midrst_data_out", int'(data_out), 0);
    chk("midrst_carry", int'(carry_flag), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    @(negedge clk);
    chk("midrst_no_late_done", int'(done), 0);
    send(1'b0, 4'h0, 3'd3, 3'd3, 3'd5, 1'b0, 8'h00);
    wait_done();
    chk("post_rst_add", int'(data_out), 8'h00);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
